logic_mod_counter: RTL

Parametrised synchronous modulo-N up/down counter for the TTM4 emulator logic library, the general-purpose successor to the fixed 4-bit binary counter part. It provides configurable width and modulus, direction control, synchronous clear, parallel load, 74-series style ENP/ENT cascading with a combinational ripple carry, a sticky overflow flag and a compare-match output. It serves as the program counter, prescaler and timer primitive in emulated CPU and peripheral logic.

---
 rtl/logic_mod_counter.sv | 71 +++++++
 1 files changed

// File: rtl/logic_mod_counter.sv
// logic_mod_counter: modulo-N up/down counter with parallel load and ENP/ENT cascading.
// It also has a ripple carry, a sticky wrap flag and a compare-match output.
module logic_mod_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 2**WIDTH
) (
   input  logic             CK,
   input  logic             CLR,
   input  logic             SCLR,
   input  logic             nLOAD,
   input  logic             ENP,
   input  logic             ENT,
   input  logic             UP,
   input  logic [WIDTH-1:0] DATAIN,
   input  logic [WIDTH-1:0] CMP,
   input  logic             OVF_CLR,
   output logic [WIDTH-1:0] COUNTER,
   output logic             TC,
   output logic             RCO,
   output logic             OVF,
   output logic             MATCH
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   logic             step;
   logic             wrap;
   logic [WIDTH-1:0] step_value;
   logic [WIDTH-1:0] count_next;

   // Out-of-range loaded values count as terminal when counting up, so they wrap to 0.
   assign TC    = UP ? (COUNTER >= LAST) : (COUNTER == '0);
   assign RCO   = TC & ENT;
   assign MATCH = (COUNTER == CMP);
   assign step  = ENP & ENT;
   assign wrap  = step & TC;

   // NOTE: each variable is given a default first, so no path through the if/else chain can infer a latch.
   always_comb begin
      step_value = '0;
      count_next = COUNTER;
      if (UP) begin
         step_value = TC ? '0 : COUNTER + WIDTH'(1);
      end else begin
         step_value = TC ? LAST : COUNTER - WIDTH'(1);
      end
      if (SCLR) begin
         count_next = '0;
      end else if (!nLOAD) begin
         count_next = DATAIN;
      end else if (step) begin
         count_next = step_value;
      end
   end

   // NOTE: registered state uses non-blocking assignments, so every flop samples values from before the edge.
   always_ff @(posedge CK or posedge CLR) begin
      if (CLR) begin
         COUNTER <= '0;
         OVF     <= 1'b0;
      end else begin
         COUNTER <= count_next;
         if (wrap) begin
            OVF <= 1'b1;
         end else if (OVF_CLR) begin
            OVF <= 1'b0;
         end
      end
   end

endmodule
